// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one sequential 8x8 multiplier
// between NUM_REQ requesters. Latches the winner's operands, pulses the multiplier
// enable, waits for a fresh done plus a BCD settle window, then returns the result.
// Optional feature: define MULT_TIMEOUT_EN to bound the wait for the multiplier's done
// (TIMEOUT_CYC cycles); a timed-out request answers with rsp_err=1 and zero results.
module mult_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned BCD_WAIT    = 12,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [8*NUM_REQ-1:0]   req_y,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [15:0]            rsp_prod,
   output logic [18:0]            rsp_bcd,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   mul_en,
   output logic [7:0]             mul_x,
   output logic [7:0]             mul_y,
   input  logic                   mul_done,
   input  logic [15:0]            mul_prod,
   input  logic [18:0]            mul_bcd
);

   localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // A zero settle window still needs one SETTLE cycle to sample the BCD value.
   localparam int unsigned EffWait = (BCD_WAIT == 0) ? 1 : BCD_WAIT;
   localparam int unsigned CntMax  = (EffWait > TIMEOUT_CYC) ? EffWait : TIMEOUT_CYC;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StLaunch, StWait, StSettle, StResp} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [7:0]        mul_x_q, mul_x_d;
   logic [7:0]        mul_y_q, mul_y_d;
   logic              seen_low_q, seen_low_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [15:0]       rsp_prod_q, rsp_prod_d;
   logic [18:0]       rsp_bcd_q, rsp_bcd_d;
`ifdef MULT_TIMEOUT_EN
   logic              err_q, err_d;
   logic              timeout_hit;
`endif

   logic              arb_found;
   logic [IdxW-1:0]   arb_idx;
   logic [IdxW-1:0]   cand;
   logic [7:0]        arb_x, arb_y;
   logic [NUM_REQ-1:0] grant_oh;
   logic              qual_done;
   logic              settle_last;

   // A done level only counts once it has been seen low after the launch; a done
   // still high from the previous operation must not end the wait.
   assign qual_done   = mul_done & seen_low_q;
   assign settle_last = (cnt_q == CntW'(EffWait - 1));
`ifdef MULT_TIMEOUT_EN
   assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`endif

   // Round-robin pick: first pending requester above the last grant, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = ptr_q;
      cand      = ptr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (cand == IdxW'(NUM_REQ - 1)) begin
            cand = '0;
         end else begin
            cand = cand + IdxW'(1);
         end
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // Operand mux for the arbitration winner, plus one-hot of the registered grant.
   always_comb begin
      arb_x    = '0;
      arb_y    = '0;
      grant_oh = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IdxW'(i)) begin
            arb_x = req_x[8*i +: 8];
            arb_y = req_y[8*i +: 8];
         end
         grant_oh[i] = (grant_q == IdxW'(i));
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (arb_found) state_d = StLaunch;
         StLaunch: state_d = StWait;
         StWait: begin
            if (qual_done) begin
               state_d = StSettle;
`ifdef MULT_TIMEOUT_EN
            end else if (timeout_hit) begin
               state_d = StResp;
`endif
            end
         end
         StSettle: if (settle_last) state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath next-state: grant/operand latch, done qualification, counters, results.
   always_comb begin
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      mul_x_d    = mul_x_q;
      mul_y_d    = mul_y_q;
      seen_low_d = seen_low_q;
      cnt_d      = cnt_q;
      rsp_prod_d = rsp_prod_q;
      rsp_bcd_d  = rsp_bcd_q;
`ifdef MULT_TIMEOUT_EN
      err_d      = err_q;
`endif
      case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_d = arb_idx;
               mul_x_d = arb_x;
               mul_y_d = arb_y;
            end
         end
         StLaunch: begin
            ptr_d      = grant_q;
            seen_low_d = 1'b0;
            cnt_d      = '0;
`ifdef MULT_TIMEOUT_EN
            err_d      = 1'b0;
`endif
         end
         StWait: begin
            if (!mul_done) seen_low_d = 1'b1;
            if (qual_done) begin
               rsp_prod_d = mul_prod;
               cnt_d      = '0;
`ifdef MULT_TIMEOUT_EN
            end else if (timeout_hit) begin
               rsp_prod_d = '0;
               rsp_bcd_d  = '0;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end
         StSettle: begin
            cnt_d = cnt_q + CntW'(1);
            if (settle_last) rsp_bcd_d = mul_bcd;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q    <= '0;
         ptr_q      <= IdxW'(NUM_REQ - 1);
         mul_x_q    <= '0;
         mul_y_q    <= '0;
         seen_low_q <= 1'b0;
         cnt_q      <= '0;
         rsp_prod_q <= '0;
         rsp_bcd_q  <= '0;
`ifdef MULT_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         mul_x_q    <= mul_x_d;
         mul_y_q    <= mul_y_d;
         seen_low_q <= seen_low_d;
         cnt_q      <= cnt_d;
         rsp_prod_q <= rsp_prod_d;
         rsp_bcd_q  <= rsp_bcd_d;
`ifdef MULT_TIMEOUT_EN
         err_q      <= err_d;
`endif
      end
   end

   // State-decoded outputs: launch and response pulses, busy flag.
   always_comb begin
      ack       = '0;
      rsp_valid = '0;
      mul_en    = 1'b0;
      rsp_err   = 1'b0;
      busy      = (state_q != StIdle);
      if (state_q == StLaunch) begin
         mul_en = 1'b1;
         ack    = grant_oh;
      end
      if (state_q == StResp) begin
         rsp_valid = grant_oh;
`ifdef MULT_TIMEOUT_EN
         rsp_err   = err_q;
`endif
      end
   end

   assign rsp_prod = rsp_prod_q;
   assign rsp_bcd  = rsp_bcd_q;
   assign mul_x    = mul_x_q;
   assign mul_y    = mul_y_q;

endmodule
